// File: rtl/block_checker_pkg.sv
// Shared types and constants for the begin/end nesting checker.
// Holds the token FSM state encoding, keyword letters and the case-fold helper.
package block_checker_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_B1,
    ST_B2,
    ST_B3,
    ST_B4,
    ST_BDONE,
    ST_E1,
    ST_E2,
    ST_EDONE,
    ST_SKIP
  } tok_state_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6e;
  localparam logic [7:0] CH_D     = 8'h64;

  // Only A-Z are folded; punctuation and digits pass through untouched.
  function automatic logic [7:0] fold_case(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5a)) ? (c | 8'h20) : c;
  endfunction

endpackage

// File: rtl/block_token_fsm.sv
// Word tokenizer: recognises space-delimited begin/end, flags the tentative token and commit strobes.
// State updates one cycle after an accepted character; in_valid low simply holds the state.
module block_token_fsm
  import block_checker_pkg::*;
#(
  parameter int CASE_SENS = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic       pend_inc,
  output logic       pend_dec,
  output logic       commit_inc,
  output logic       commit_dec
);

  tok_state_t state, state_nxt;
  logic [7:0] ch;
  logic       is_space;

  assign ch       = (CASE_SENS != 0) ? in : fold_case(in);
  assign is_space = (ch == CH_SPACE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (in_valid) begin
      if (is_space) begin
        state_nxt = ST_IDLE;
      end else begin
        state_nxt = ST_SKIP;
        case (state)
          ST_IDLE: begin
            if (ch == CH_B)      state_nxt = ST_B1;
            else if (ch == CH_E) state_nxt = ST_E1;
          end
          ST_B1: if (ch == CH_E) state_nxt = ST_B2;
          ST_B2: if (ch == CH_G) state_nxt = ST_B3;
          ST_B3: if (ch == CH_I) state_nxt = ST_B4;
          ST_B4: if (ch == CH_N) state_nxt = ST_BDONE;
          ST_E1: if (ch == CH_N) state_nxt = ST_E2;
          ST_E2: if (ch == CH_D) state_nxt = ST_EDONE;
          default: state_nxt = ST_SKIP;
        endcase
      end
    end
  end

  assign pend_inc   = (state == ST_BDONE);
  assign pend_dec   = (state == ST_EDONE);
  // Commit only on the space that closes a completed keyword.
  assign commit_inc = in_valid && is_space && pend_inc;
  assign commit_dec = in_valid && is_space && pend_dec;

endmodule

// File: rtl/block_nest_checker.sv
// Streaming begin/end nesting checker with depth counter and sticky under/overflow flags.
// Outputs reflect a character one cycle after its sampling edge; in_valid low stalls everything.
module block_nest_checker
  import block_checker_pkg::*;
#(
  parameter int DEPTH_W   = 8,
  parameter int CASE_SENS = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               underflow,
  output logic               overflow
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  logic pend_inc, pend_dec, commit_inc, commit_dec;
  logic signed [DEPTH_W:0] pend_s;
  logic signed [DEPTH_W:0] level;

  block_token_fsm #(
    .CASE_SENS (CASE_SENS)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .in_valid   (in_valid),
    .pend_inc   (pend_inc),
    .pend_dec   (pend_dec),
    .commit_inc (commit_inc),
    .commit_dec (commit_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      depth     <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else if (commit_inc) begin
      if (depth == DEPTH_MAX) overflow <= 1'b1;
      else                    depth    <= depth + 1'b1;
    end else if (commit_dec) begin
      if (depth == '0) underflow <= 1'b1;
      else             depth     <= depth - 1'b1;
    end
  end

  always_comb begin
    pend_s = '0;
    if (pend_inc)      pend_s = {{DEPTH_W{1'b0}}, 1'b1};
    else if (pend_dec) pend_s = '1;
  end

  // Tentative token counts toward balance, so a trailing "end" at depth 0 reads unbalanced.
  assign level  = $signed({1'b0, depth}) + pend_s;
  assign result = !underflow && !overflow && (level == '0);

endmodule

// File: tb/tb_block_nest_checker.sv
module tb_block_nest_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in = 8'h00;
  logic       in_valid = 1'b0;

  logic       res [3];
  logic [7:0] dep [3];
  logic       uf  [3];
  logic       of  [3];
  logic [1:0] dep1;

  int nchk = 0;
  int nerr = 0;

  // Reference state per instance: current word text, committed depth, flags.
  string mword [3];
  int    mdepth[3];
  bit    muf   [3];
  bit    mof   [3];
  int    mmax  [3] = '{255, 3, 255};
  bit    mcs   [3] = '{1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  block_nest_checker #(.DEPTH_W(8), .CASE_SENS(0)) u0 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .result(res[0]), .depth(dep[0]), .underflow(uf[0]), .overflow(of[0]));

  block_nest_checker #(.DEPTH_W(2), .CASE_SENS(0)) u1 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .result(res[1]), .depth(dep1), .underflow(uf[1]), .overflow(of[1]));

  block_nest_checker #(.DEPTH_W(8), .CASE_SENS(1)) u2 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .result(res[2]), .depth(dep[2]), .underflow(uf[2]), .overflow(of[2]));

  assign dep[1] = {6'b0, dep1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int kw_value(input string w, input bit cs);
    string t;
    t = cs ? w : w.tolower();
    if (t == "begin") return 1;
    if (t == "end")   return -1;
    return 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mword[i] = ""; mdepth[i] = 0; muf[i] = 0; mof[i] = 0;
    end
  endfunction

  function automatic void model_char(input logic [7:0] c);
    int p;
    for (int i = 0; i < 3; i++) begin
      if (c == 8'h20) begin
        p = kw_value(mword[i], mcs[i]);
        if (p == 1) begin
          if (mdepth[i] < mmax[i]) mdepth[i]++;
          else mof[i] = 1;
        end else if (p == -1) begin
          if (mdepth[i] > 0) mdepth[i]--;
          else muf[i] = 1;
        end
        mword[i] = "";
      end else if (mword[i].len() < 6) begin
        mword[i] = $sformatf("%s%c", mword[i], c);
      end
    end
  endfunction

  task automatic compare_all();
    int  p;
    bit  er;
    for (int i = 0; i < 3; i++) begin
      p  = kw_value(mword[i], mcs[i]);
      er = !muf[i] && !mof[i] && (mdepth[i] + p == 0);
      check($sformatf("u%0d.result", i), 32'(res[i]), 32'(er));
      check($sformatf("u%0d.depth", i), 32'(dep[i]), 32'(mdepth[i]));
      check($sformatf("u%0d.underflow", i), 32'(uf[i]), 32'(muf[i]));
      check($sformatf("u%0d.overflow", i), 32'(of[i]), 32'(mof[i]));
    end
  endtask

  task automatic step(input logic [7:0] c, input logic v, input logic r);
    @(negedge clk);
    in = c; in_valid = v; reset = r;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else if (v) model_char(c);
    compare_all();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i], 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    step(8'h20, 1'b1, 1'b1);
    step($urandom_range(32, 126), 1'b0, 1'b0);
  endtask

  string words[12] = '{"begin", "end", "BEGIN", "bEgIn", "EnD", "beginx", "ends",
                       "en", "begi", "x", "b3gin", "e"};

  initial begin
    string w;
    byte   c;
    model_reset();
    do_reset();

    // Directed sequences
    send_str("a BEGin end ");
    send_str("beginx ");
    send_str("end begin end ");
    do_reset();
    send_str("begin begin begin begin ");
    do_reset();
    send_str("be");
    for (int k = 0; k < 3; k++) step("g", 1'b0, 1'b0);
    send_str("gin ");
    do_reset();
    send_str("beg");
    do_reset();
    send_str("in ");
    send_str("BEGIN ");
    send_str("begin   end   ");
    send_str("end");
    for (int k = 0; k < 4; k++) step(8'h20, 1'b0, 1'b0);
    send_str(" ");
    do_reset();

    // Randomized word stream with stalls and occasional resets
    for (int n = 0; n < 400; n++) begin
      w = words[$urandom_range(0, 11)];
      for (int i = 0; i < w.len(); i++) begin
        if ($urandom_range(0, 80) == 0) do_reset();
        while ($urandom_range(0, 3) == 0) step($urandom_range(32, 126), 1'b0, 1'b0);
        c = w[i];
        if (c >= "a" && c <= "z" && $urandom_range(0, 5) == 0) c = c - 8'h20;
        step(c, 1'b1, 1'b0);
      end
      for (int s = 0; s < $urandom_range(1, 2); s++) step(8'h20, 1'b1, 1'b0);
      if ($urandom_range(0, 25) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
